pacoblaze_lockstep_monitor: RTL

Synthesizable lockstep checker that sits directly downstream of two PicoBlaze-compatible cores (PacoBlaze3m and KCPSM3) executing the same program image from separate ROMs. Every cycle it compares the two cores' instruction-address and port-bus outputs and counts run cycles. It latches the first divergence with its cycle number and cause, and reports pass or fail once the run is complete. It replaces display-based comparison with a hardware verdict usable on-chip and in regression.

---
 rtl/pacoblaze_lockstep_monitor_pkg.sv | 21 ++
 rtl/pacoblaze_lockstep_monitor_compare.sv | 38 +++
 rtl/pacoblaze_lockstep_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pacoblaze_lockstep_monitor_pkg.sv
// rtl/pacoblaze_lockstep_monitor_pkg.sv - shared widths, fail_kind bit positions and FSM encodings
package pacoblaze_lockstep_monitor_pkg;

    // Core geometry shared by both PicoBlaze-compatible cores
    localparam int CODE_DEPTH    = 10;
    localparam int OPERAND_WIDTH = 8;

    // Bit positions inside the 4-bit mismatch cause mask
    localparam int KIND_ADDR   = 0;
    localparam int KIND_STROBE = 1;
    localparam int KIND_PORTID = 2;
    localparam int KIND_OUTPRT = 3;
    localparam int KIND_W      = 4;

    // Monitor FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

endpackage

// File: rtl/pacoblaze_lockstep_monitor_compare.sv
// rtl/pacoblaze_lockstep_monitor_compare.sv - combinational per-cycle bus comparison of two cores
module lockstep_compare
    import pacoblaze_lockstep_monitor_pkg::*;
#(
    parameter int ADDR_W = CODE_DEPTH,
    parameter int DATA_W = OPERAND_WIDTH
) (
    input  logic [ADDR_W-1:0] a_address,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] a_port_id,
    input  logic [DATA_W-1:0] b_port_id,
    input  logic [DATA_W-1:0] a_out_port,
    input  logic [DATA_W-1:0] b_out_port,
    input  logic              a_read_strobe,
    input  logic              b_read_strobe,
    input  logic              a_write_strobe,
    input  logic              b_write_strobe,
    input  logic              a_interrupt_ack,
    input  logic              b_interrupt_ack,
    output logic [KIND_W-1:0] flags
);

    logic port_active;
    logic write_active;

    // Port id only matters on an I/O access; out_port only on a write
    always_comb begin
        port_active  = a_read_strobe | b_read_strobe | a_write_strobe | b_write_strobe;
        write_active = a_write_strobe | b_write_strobe;
        flags = '0;
        flags[KIND_ADDR]   = (a_address != b_address);
        flags[KIND_STROBE] = ({a_read_strobe, a_write_strobe, a_interrupt_ack} !=
                              {b_read_strobe, b_write_strobe, b_interrupt_ack});
        flags[KIND_PORTID] = port_active  && (a_port_id  != b_port_id);
        flags[KIND_OUTPRT] = write_active && (a_out_port != b_out_port);
    end

endmodule

// File: rtl/pacoblaze_lockstep_monitor.sv
// rtl/pacoblaze_lockstep_monitor.sv - lockstep verdict FSM, cycle counter and first-mismatch capture
module pacoblaze_lockstep_monitor
    import pacoblaze_lockstep_monitor_pkg::*;
#(
    parameter int ADDR_W = CODE_DEPTH,
    parameter int DATA_W = OPERAND_WIDTH,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CYC_W-1:0]  cycle_limit,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] a_port_id,
    input  logic [DATA_W-1:0] b_port_id,
    input  logic [DATA_W-1:0] a_out_port,
    input  logic [DATA_W-1:0] b_out_port,
    input  logic              a_read_strobe,
    input  logic              b_read_strobe,
    input  logic              a_write_strobe,
    input  logic              b_write_strobe,
    input  logic              a_interrupt_ack,
    input  logic              b_interrupt_ack,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [CYC_W-1:0]  fail_cycle,
    output logic [3:0]        fail_kind,
    output logic [ADDR_W-1:0] fail_addr_a,
    output logic [ADDR_W-1:0] fail_addr_b
);

    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    logic [1:0]        state_q, state_d;
    logic [CYC_W-1:0]  count_q, count_d;
    logic [CYC_W-1:0]  fail_cycle_q, fail_cycle_d;
    logic [3:0]        fail_kind_q, fail_kind_d;
    logic [ADDR_W-1:0] fail_addr_a_q, fail_addr_a_d;
    logic [ADDR_W-1:0] fail_addr_b_q, fail_addr_b_d;
    logic [KIND_W-1:0] flags;
    logic [CYC_W-1:0]  count_inc;

    lockstep_compare #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_compare (
        .a_address       (a_address),
        .b_address       (b_address),
        .a_port_id       (a_port_id),
        .b_port_id       (b_port_id),
        .a_out_port      (a_out_port),
        .b_out_port      (b_out_port),
        .a_read_strobe   (a_read_strobe),
        .b_read_strobe   (b_read_strobe),
        .a_write_strobe  (a_write_strobe),
        .b_write_strobe  (b_write_strobe),
        .a_interrupt_ack (a_interrupt_ack),
        .b_interrupt_ack (b_interrupt_ack),
        .flags           (flags)
    );

    // Next-state: enable low dominates everything, then mismatch beats limit
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        fail_cycle_d  = fail_cycle_q;
        fail_kind_d   = fail_kind_q;
        fail_addr_a_d = fail_addr_a_q;
        fail_addr_b_d = fail_addr_b_q;
        count_inc     = (count_q == '1) ? count_q : count_q + CYC_ONE;

        if (!enable) begin
            state_d       = ST_IDLE;
            count_d       = '0;
            fail_cycle_d  = '0;
            fail_kind_d   = '0;
            fail_addr_a_d = '0;
            fail_addr_b_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    count_d = '0;
                end
                ST_RUN: begin
                    count_d = count_inc;
                    if (flags != '0) begin
                        state_d       = ST_FAIL;
                        fail_cycle_d  = count_q;
                        fail_kind_d   = flags;
                        fail_addr_a_d = a_address;
                        fail_addr_b_d = b_address;
                    end else if ((cycle_limit != '0) && (count_q == cycle_limit - CYC_ONE)) begin
                        state_d = ST_PASS;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and capture registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            fail_cycle_q  <= '0;
            fail_kind_q   <= '0;
            fail_addr_a_q <= '0;
            fail_addr_b_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            fail_cycle_q  <= fail_cycle_d;
            fail_kind_q   <= fail_kind_d;
            fail_addr_a_q <= fail_addr_a_d;
            fail_addr_b_q <= fail_addr_b_d;
        end
    end

    // Outputs are decodes of registered state only
    always_comb begin
        busy        = (state_q == ST_RUN);
        pass        = (state_q == ST_PASS);
        fail        = (state_q == ST_FAIL);
        cycle_count = count_q;
        fail_cycle  = fail_cycle_q;
        fail_kind   = fail_kind_q;
        fail_addr_a = fail_addr_a_q;
        fail_addr_b = fail_addr_b_q;
    end

endmodule
